// File: rtl/gpio_irq_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gpio_irq_pkg
// Description : Shared limits and vector type for the GPIO edge/level IRQ path.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_irq_pkg;

  localparam int GPIO_WIDTH_MAX = 32;
  localparam int SYNC_DEPTH_MIN = 2;

  // Full-width container for pin vectors; instances use the low WIDTH bits.
  typedef logic [GPIO_WIDTH_MAX-1:0] gpio_vec_t;

endpackage : gpio_irq_pkg
`default_nettype wire

// File: rtl/async_sync_chain.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : async_sync_chain
// Description : Single-bit multi-flop synchronizer, asynchronously reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module async_sync_chain
  import gpio_irq_pkg::*;
#(
  parameter int SYNC_DEPTH = 3
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  // Depths below the metastability minimum are raised rather than honoured.
  localparam int c_DEPTH = (SYNC_DEPTH < SYNC_DEPTH_MIN) ? SYNC_DEPTH_MIN : SYNC_DEPTH;

  logic [c_DEPTH-1:0] r_stage;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stage <= '0;
    end else begin
      r_stage <= {r_stage[c_DEPTH-2:0], d};
    end
  end

  assign q = r_stage[c_DEPTH-1];

endmodule : async_sync_chain
`default_nettype wire

// File: rtl/gpio_edge_irq_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : gpio_edge_irq_capture
// Description : Per-pin synchronizers feeding rise/fall/high/low detection,
//               sticky W1C pending bits and one registered interrupt line.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_edge_irq_capture
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int SYNC_DEPTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_in,
  input  logic [WIDTH-1:0] io_rise_en,
  input  logic [WIDTH-1:0] io_fall_en,
  input  logic [WIDTH-1:0] io_high_en,
  input  logic [WIDTH-1:0] io_low_en,
  input  logic             io_clr_valid,
  input  logic [WIDTH-1:0] io_clr_mask,
  output logic [WIDTH-1:0] io_sync_value,
  output logic [WIDTH-1:0] io_pending,
  output logic             io_irq
);

  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] w_pending_next;

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_pending;
  logic             r_primed;
  logic             r_irq;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
    async_sync_chain #(
      .SYNC_DEPTH (SYNC_DEPTH)
    ) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (io_in[gi]),
      .q     (w_sync[gi])
    );
  end

  assign w_rise = w_sync & ~r_prev;
  assign w_fall = ~w_sync & r_prev;

  // Every detect source, including levels, waits for primed so the first
  // cycle out of reset never reports anything.
  assign w_hit = {WIDTH{r_primed}} &
                 ((w_rise & io_rise_en) | (w_fall & io_fall_en) |
                  (w_sync & io_high_en) | (~w_sync & io_low_en));

  assign w_clr          = {WIDTH{io_clr_valid}} & io_clr_mask;
  assign w_pending_next = w_hit | (r_pending & ~w_clr);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_prev    <= '0;
      r_pending <= '0;
      r_primed  <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_prev    <= w_sync;
      r_pending <= w_pending_next;
      r_primed  <= 1'b1;
      // Built from the next-state vector so irq rises with pending, not after.
      r_irq     <= |w_pending_next;
    end
  end

  assign io_sync_value = w_sync;
  assign io_pending    = r_pending;
  assign io_irq        = r_irq;

endmodule : gpio_edge_irq_capture
`default_nettype wire

// File: tb/tb_gpio_edge_irq_capture.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_gpio_edge_irq_capture
// Description : Directed self-checking bench for gpio_edge_irq_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_edge_irq_capture;

  localparam int WIDTH      = 8;
  localparam int SYNC_DEPTH = 3;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] io_in;
  logic [WIDTH-1:0] io_rise_en;
  logic [WIDTH-1:0] io_fall_en;
  logic [WIDTH-1:0] io_high_en;
  logic [WIDTH-1:0] io_low_en;
  logic             io_clr_valid;
  logic [WIDTH-1:0] io_clr_mask;
  logic [WIDTH-1:0] io_sync_value;
  logic [WIDTH-1:0] io_pending;
  logic             io_irq;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  gpio_edge_irq_capture #(
    .WIDTH      (WIDTH),
    .SYNC_DEPTH (SYNC_DEPTH)
  ) dut (
    .clock         (clk),
    .reset         (rst),
    .io_in         (io_in),
    .io_rise_en    (io_rise_en),
    .io_fall_en    (io_fall_en),
    .io_high_en    (io_high_en),
    .io_low_en     (io_low_en),
    .io_clr_valid  (io_clr_valid),
    .io_clr_mask   (io_clr_mask),
    .io_sync_value (io_sync_value),
    .io_pending    (io_pending),
    .io_irq        (io_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst          = 1'b1;
    io_in        = 8'h00;
    io_rise_en   = 8'h00;
    io_fall_en   = 8'h00;
    io_high_en   = 8'h00;
    io_low_en    = 8'h00;
    io_clr_valid = 1'b0;
    io_clr_mask  = 8'h00;
    step(3);
    chk("reset_pending", 32'(io_pending), 32'h00);
    chk("reset_irq",     32'(io_irq),     32'h0);
    chk("reset_sync",    32'(io_sync_value), 32'h00);

    // Pins high and rise enabled across reset release: nothing during refill;
    // the chain resets to 0, so it then sees a genuine 0->1 at edge 4.
    io_in      = 8'hFF;
    io_rise_en = 8'hFF;
    step(1);
    rst = 1'b0;
    for (int k = 1; k <= SYNC_DEPTH; k++) begin
      step(1);
      chk($sformatf("post_reset_quiet_e%0d", k), 32'(io_pending), 32'h00);
      chk($sformatf("post_reset_irq_e%0d", k),   32'(io_irq),     32'h0);
    end
    chk("post_reset_sync", 32'(io_sync_value), 32'hFF);
    step(1);
    chk("post_reset_rise_pending", 32'(io_pending), 32'hFF);
    chk("post_reset_rise_irq",     32'(io_irq),     32'h1);
    io_rise_en   = 8'h00;
    io_clr_valid = 1'b1;
    io_clr_mask  = 8'hFF;
    step(1);
    io_clr_valid = 1'b0;
    chk("clr_all_pending", 32'(io_pending), 32'h00);
    chk("clr_all_irq",     32'(io_irq),     32'h0);
    for (int k = 0; k < 10; k++) begin
      step(1);
      chk("steady_high_no_irq", 32'({io_irq, io_pending}), 32'h000);
    end

    // Rise on bit 2: sync after 3 edges, pending/irq after 4.
    io_in = 8'h00;
    step(5);
    io_rise_en = 8'h04;
    io_in      = 8'h04;
    step(2);
    chk("rise_sync_e2", 32'(io_sync_value), 32'h00);
    step(1);
    chk("rise_sync_e3",    32'(io_sync_value), 32'h04);
    chk("rise_pending_e3", 32'(io_pending),    32'h00);
    step(1);
    chk("rise_pending_e4", 32'(io_pending), 32'h04);
    chk("rise_irq_e4",     32'(io_irq),     32'h1);

    // W1C with and without qualifier.
    io_clr_valid = 1'b1;
    io_clr_mask  = 8'h04;
    step(1);
    io_clr_valid = 1'b0;
    chk("w1c_pending", 32'(io_pending), 32'h00);
    chk("w1c_irq",     32'(io_irq),     32'h0);
    io_in = 8'h00;
    step(4);
    io_in = 8'h04;
    step(4);
    chk("rerise_pending", 32'(io_pending), 32'h04);
    io_clr_mask = 8'h04;
    step(1);
    chk("clr_unqualified", 32'(io_pending), 32'h04);
    io_clr_valid = 1'b1;
    io_clr_mask  = 8'h01;
    step(1);
    chk("clr_zero_bit_pending", 32'(io_pending), 32'h04);
    chk("clr_zero_bit_irq",     32'(io_irq),     32'h1);
    io_clr_mask = 8'h04;
    step(1);
    io_clr_valid = 1'b0;
    chk("cleanup_pending", 32'(io_pending), 32'h00);

    // Fall on bit 5 coinciding with a clear of bit 5: set wins.
    io_fall_en = 8'h20;
    io_in      = 8'h24;
    step(5);
    chk("bit5_rise_ignored", 32'(io_pending), 32'h00);
    io_in = 8'h04;
    step(3);
    chk("fall_before_detect", 32'(io_pending), 32'h00);
    io_clr_valid = 1'b1;
    io_clr_mask  = 8'h20;
    step(1);
    chk("fall_set_wins_pending", 32'(io_pending), 32'h20);
    chk("fall_set_wins_irq",     32'(io_irq),     32'h1);
    step(1);
    io_clr_valid = 1'b0;
    chk("fall_cleared_pending", 32'(io_pending), 32'h00);
    chk("fall_cleared_irq",     32'(io_irq),     32'h0);
    io_fall_en = 8'h00;

    // Level-high on bit 0 held: a clear cannot win against a live hit.
    io_high_en = 8'h01;
    io_in      = 8'h05;
    step(3);
    chk("high_before_detect", 32'(io_pending), 32'h00);
    step(1);
    chk("high_detect", 32'(io_pending), 32'h01);
    io_clr_valid = 1'b1;
    io_clr_mask  = 8'h01;
    step(1);
    io_clr_valid = 1'b0;
    chk("high_clr_held_pending", 32'(io_pending), 32'h01);
    chk("high_clr_held_irq",     32'(io_irq),     32'h1);
    step(1);
    chk("high_still_pending", 32'(io_pending), 32'h01);
    io_high_en   = 8'h00;
    io_clr_valid = 1'b1;
    step(1);
    io_clr_valid = 1'b0;
    chk("high_disabled_clr", 32'(io_pending), 32'h00);
    io_low_en = 8'h80;
    step(1);
    chk("low_detect_pending", 32'(io_pending), 32'h80);
    chk("low_detect_irq",     32'(io_irq),     32'h1);
    io_low_en    = 8'h00;
    io_clr_valid = 1'b1;
    io_clr_mask  = 8'h80;
    step(1);
    io_clr_valid = 1'b0;
    chk("low_cleared", 32'(io_pending), 32'h00);

    // Mid-run reset with pending A5, then priming on release.
    io_in      = 8'hA5;
    io_high_en = 8'hA5;
    step(4);
    chk("pre_reset_pending", 32'(io_pending), 32'hA5);
    chk("pre_reset_irq",     32'(io_irq),     32'h1);
    #3;
    rst       = 1'b1;
    io_low_en = 8'h5A;
    #1;
    chk("async_reset_pending", 32'(io_pending),    32'h00);
    chk("async_reset_irq",     32'(io_irq),        32'h0);
    chk("async_reset_sync",    32'(io_sync_value), 32'h00);
    step(1);
    rst = 1'b0;
    step(1);
    chk("primed_gate_pending", 32'(io_pending), 32'h00);
    chk("primed_gate_irq",     32'(io_irq),     32'h0);
    step(1);
    chk("primed_low_pending", 32'(io_pending), 32'h5A);
    chk("primed_low_irq",     32'(io_irq),     32'h1);
    step(2);
    chk("refilled_pending", 32'(io_pending), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_gpio_edge_irq_capture
`default_nettype wire
